// File: rtl/aes_cbc_dec_ctrl_if.sv
// Handshake and data bundle between the SoC-side driver and the CBC decrypt controller.
interface aes_cbc_dec_ctrl_if;
    localparam int unsigned BLK_W = 128;
    localparam int unsigned CNT_W = 16;

    logic             start;
    logic [BLK_W-1:0] iv;
    logic [BLK_W-1:0] key;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] out_data;
    logic             out_last;
    logic [CNT_W-1:0] blk_cnt;

    modport master (
        output start, iv, key, in_valid, in_data, in_last, out_ready,
        input  busy, in_ready, out_valid, out_data, out_last, blk_cnt
    );

    modport slave (
        input  start, iv, key, in_valid, in_data, in_last, out_ready,
        output busy, in_ready, out_valid, out_data, out_last, blk_cnt
    );
endinterface

// File: rtl/aes_cbc_dec_ctrl.sv
// AES-128 CBC decryption controller with a combinational inverse-cipher core.

// Combinational AES-128 inverse cipher: full key schedule plus ten unrolled rounds.
module aes_decr (
    input  logic         rst,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic [127:0] out
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] isb(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant built from x, 2x, 4x, 8x.
    function automatic logic [7:0] gm(input logic [7:0] x, input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return (m[0] ? x : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gm(a0, 4'd14) ^ gm(a1, 4'd11) ^ gm(a2, 4'd13) ^ gm(a3, 4'd9),
                gm(a0, 4'd9)  ^ gm(a1, 4'd14) ^ gm(a2, 4'd11) ^ gm(a3, 4'd13),
                gm(a0, 4'd13) ^ gm(a1, 4'd9)  ^ gm(a2, 4'd14) ^ gm(a3, 4'd11),
                gm(a0, 4'd11) ^ gm(a1, 4'd13) ^ gm(a2, 4'd9)  ^ gm(a3, 4'd14)};
    endfunction

    // Row r of the column-major state rotates right by r bytes.
    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        return {s[127:120], s[23:16],   s[47:40],  s[71:64],
                s[95:88],   s[119:112], s[15:8],   s[39:32],
                s[63:56],   s[87:80],   s[111:104], s[7:0],
                s[31:24],   s[55:48],   s[79:72],  s[103:96]};
    endfunction

    // Forward key expansion into 44 words.
    for (genvar i = 0; i < 44; i++) begin : g_w
        logic [31:0] v;
        if (i < 4) begin : g_key
            assign v = key[127-32*i -: 32];
        end else if (i % 4 == 0) begin : g_rot
            assign v = g_w[i-4].v ^ sub_word({g_w[i-1].v[23:0], g_w[i-1].v[31:24]})
                     ^ {RCON[79-8*(i/4-1) -: 8], 24'h000000};
        end else begin : g_lin
            assign v = g_w[i-4].v ^ g_w[i-1].v;
        end
    end

    // Initial whitening with round key 10, then rounds 9 down to 1.
    for (genvar k = 0; k < 10; k++) begin : g_st
        logic [127:0] v;
        if (k == 0) begin : g_init
            assign v = in ^ {g_w[40].v, g_w[41].v, g_w[42].v, g_w[43].v};
        end else begin : g_rnd
            localparam int unsigned R = 10 - k;
            logic [127:0] sh;
            logic [127:0] sub;
            assign sh = inv_shift(g_st[k-1].v);
            for (genvar j = 0; j < 16; j++) begin : g_sub
                assign sub[127-8*j -: 8] = isb(sh[127-8*j -: 8]);
            end
            for (genvar c = 0; c < 4; c++) begin : g_col
                assign v[127-32*c -: 32] = inv_mix_col(sub[127-32*c -: 32] ^ g_w[4*R+c].v);
            end
        end
    end

    // Final round without column mixing, keyed by the cipher key itself.
    logic [127:0] fin_sh;
    logic [127:0] fin_sub;
    assign fin_sh = inv_shift(g_st[9].v);
    for (genvar j = 0; j < 16; j++) begin : g_fin_sub
        assign fin_sub[127-8*j -: 8] = isb(fin_sh[127-8*j -: 8]);
    end
    assign out = rst ? '0 : (fin_sub ^ {g_w[0].v, g_w[1].v, g_w[2].v, g_w[3].v});
endmodule

// Block sequencer: accept ciphertext, wait CORE_LAT cycles for the core, present chained plaintext.
module aes_cbc_dec_ctrl #(
    parameter int unsigned CORE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    aes_cbc_dec_ctrl_if.slave  bus
);
    localparam int unsigned BLK_W = 128;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LAT_W = 4;
    localparam logic [LAT_W-1:0] LAT_END = LAT_W'(CORE_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_IN, CALC, HOLD} state_t;

    state_t           state;
    logic [BLK_W-1:0] key_reg;
    logic [BLK_W-1:0] chain;
    logic [BLK_W-1:0] ct_reg;
    logic             last_reg;
    logic [LAT_W-1:0] lat_cnt;
    logic [BLK_W-1:0] out_data_q;
    logic             out_last_q;
    logic [CNT_W-1:0] blk_cnt_q;
    logic [BLK_W-1:0] core_out;

    aes_decr u_core (
        .rst (1'b0),
        .in  (ct_reg),
        .key (key_reg),
        .out (core_out)
    );

    // Sequencer and datapath registers; core input is held in ct_reg for the settle window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            key_reg    <= '0;
            chain      <= '0;
            ct_reg     <= '0;
            last_reg   <= 1'b0;
            lat_cnt    <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        key_reg   <= bus.key;
                        chain     <= bus.iv;
                        blk_cnt_q <= '0;
                        state     <= WAIT_IN;
                    end
                end
                WAIT_IN: begin
                    if (bus.in_valid) begin
                        ct_reg   <= bus.in_data;
                        last_reg <= bus.in_last;
                        lat_cnt  <= '0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                    if (lat_cnt == LAT_END) begin
                        out_data_q <= core_out ^ chain;
                        out_last_q <= last_reg;
                        chain      <= ct_reg;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        blk_cnt_q <= blk_cnt_q + CNT_W'(1);
                        state     <= last_reg ? IDLE : WAIT_IN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags depend only on the state register.
    assign bus.busy      = (state != IDLE);
    assign bus.in_ready  = (state == WAIT_IN);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.blk_cnt   = blk_cnt_q;
endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// Directed bench for the CBC decrypt controller using SP800-38A F.2.2 vectors.
module tb_aes_cbc_dec_ctrl;
    localparam int unsigned CORE_LAT = 2;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    aes_cbc_dec_ctrl_if bus ();

    aes_cbc_dec_ctrl #(.CORE_LAT(CORE_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_start(input logic [127:0] iv, input logic [127:0] key);
        bus.start = 1'b1;
        bus.iv    = iv;
        bus.key   = key;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("start_busy", 128'(bus.busy), 128'(1));
        check("start_in_ready", 128'(bus.in_ready), 128'(1));
    endtask

    task automatic put_block(input logic [127:0] ct, input logic last);
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 128'(0), 128'(1));
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = ct;
        bus.in_last  = last;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("in_ready_drop", 128'(bus.in_ready), 128'(0));
    endtask

    // Wait for plaintext, optionally stall it for hold cycles while jittering in_valid, then accept it.
    task automatic get_block(input int hold, output logic [127:0] d, output logic l, output int lat);
        int n = 0;
        bit stable = 1'b1;
        bit rdy_low = 1'b1;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        lat = n;
        if (!bus.out_valid) begin
            check("out_valid_timeout", 128'(0), 128'(1));
            d = '0;
            l = 1'b0;
            return;
        end
        d = bus.out_data;
        l = bus.out_last;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            if (bus.out_data !== d || bus.out_last !== l || bus.out_valid !== 1'b1) stable = 1'b0;
            if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
        end
        bus.in_valid = 1'b0;
        if (hold > 0) begin
            check("bp_out_stable", 128'(stable), 128'(1));
            check("bp_in_ready_low", 128'(rdy_low), 128'(1));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        logic         l;
        int           lat;
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.iv        = '0;
        bus.key       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(0));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_data", bus.out_data, 128'(0));
        check("rst_out_last", 128'(bus.out_last), 128'(0));
        check("rst_blk_cnt", 128'(bus.blk_cnt), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single-block message with latency check
        do_start(IV, KEY);
        put_block(CT1, 1'b1);
        get_block(0, d, l, lat);
        check("t1_latency", 128'(lat), 128'(CORE_LAT));
        check("t1_data", d, PT1);
        check("t1_last", 128'(l), 128'(1));
        check("t1_blk_cnt", 128'(bus.blk_cnt), 128'(1));
        check("t1_busy", 128'(bus.busy), 128'(0));
        check("t1_out_valid", 128'(bus.out_valid), 128'(0));
        check("t1_data_kept", bus.out_data, PT1);

        // Two-block chain with backpressure and an ignored start carrying a different IV/key
        do_start(IV, KEY);
        put_block(CT1, 1'b0);
        get_block(10, d, l, lat);
        check("t2_b1_data", d, PT1);
        check("t2_b1_last", 128'(l), 128'(0));
        check("t2_in_ready_back", 128'(bus.in_ready), 128'(1));
        bus.start = 1'b1;
        bus.iv    = '1;
        bus.key   = '1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("t2_ign_busy", 128'(bus.busy), 128'(1));
        check("t2_ign_in_ready", 128'(bus.in_ready), 128'(1));
        put_block(CT2, 1'b1);
        get_block(0, d, l, lat);
        check("t2_b2_data", d, PT2);
        check("t2_b2_last", 128'(l), 128'(1));
        check("t2_blk_cnt", 128'(bus.blk_cnt), 128'(2));
        check("t2_busy", 128'(bus.busy), 128'(0));

        // start and in_valid together: only start is taken
        bus.start    = 1'b1;
        bus.iv       = IV;
        bus.key      = KEY;
        bus.in_valid = 1'b1;
        bus.in_data  = CT1;
        bus.in_last  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("t3_wait_in", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("t3_accepted", 128'(bus.in_ready), 128'(0));
        get_block(0, d, l, lat);
        check("t3_latency", 128'(lat), 128'(CORE_LAT));
        check("t3_data", d, PT1);
        check("t3_blk_cnt", 128'(bus.blk_cnt), 128'(1));

        // Reset during CALC of block 2, then rerun
        do_start(IV, KEY);
        put_block(CT1, 1'b0);
        get_block(0, d, l, lat);
        put_block(CT2, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("t4_rst_busy", 128'(bus.busy), 128'(0));
        check("t4_rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("t4_rst_out_data", bus.out_data, 128'(0));
        check("t4_rst_blk_cnt", 128'(bus.blk_cnt), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t4_idle_out_valid", 128'(bus.out_valid), 128'(0));
        do_start(IV, KEY);
        put_block(CT1, 1'b1);
        get_block(0, d, l, lat);
        check("t4_rerun_data", d, PT1);
        check("t4_rerun_blk_cnt", 128'(bus.blk_cnt), 128'(1));

        // Counter wrap from 0xFFFF
        do_start(IV, KEY);
        force dut.blk_cnt_q = 16'hffff;
        #1 release dut.blk_cnt_q;
        check("t5_preload", 128'(bus.blk_cnt), 128'(16'hffff));
        put_block(CT1, 1'b1);
        get_block(0, d, l, lat);
        check("t5_data", d, PT1);
        check("t5_wrap", 128'(bus.blk_cnt), 128'(0));
        check("t5_busy", 128'(bus.busy), 128'(0));
        do_start(IV, KEY);
        put_block(CT1, 1'b1);
        get_block(0, d, l, lat);
        check("t5_after_data", d, PT1);
        check("t5_after_cnt", 128'(bus.blk_cnt), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
